sparse_feature_encoder: RTL
===========================

// Module: sparse_feature_encoder
// PURPOSE
//  Dense-to-sparse encoder feeding the PE feature port. Accepts a raster-order pixel
//  stream, one image per frame. Emits packed (value, col, row) lists of non-zero
//  pixels in the exact flat layout the PE slices. Reports non-zero count and 4-entry group count.
//  Sits between the image/activation buffer and PE/PE_UNIT_NEW.
// PARAMETERS
//  col_length          8   bits per col/row coordinate
//  word_length         8   bits per pixel value (signed)
//  double_word_length  16  width of count outputs
//  image_size          28  image is image_size x image_size; N = image_size^2 entries
// PORTS
//  clk                 in   1                      single clock, rising edge
//  rst                 in   1                      synchronous, active-high reset
//  in_valid            in   1                      pixel_in valid this cycle
//  pixel_in            in   word_length            signed pixel, raster order (row-major)
//  in_ready            out  1                      encoder accepts pixel this cycle
//  out_valid           out  1                      1-cycle pulse: frame encoded, outputs final
//  feature_valid_num   out  double_word_length     number of non-zero pixels (nnz)
//  feature_group_num   out  double_word_length     ceil(nnz/4), PE group count
//  feature_value       out  N*word_length          entry k at [(k+1)*word_length-1 -: word_length]
//  feature_cols        out  N*col_length           entry k at [(k+1)*col_length-1 -: col_length]
//  feature_rows        out  N*col_length           same slicing as feature_cols
// BEHAVIOUR
//  - Reset: out_valid=0, in_ready=0 during rst; counters, nnz, group num = 0; all entries 0; state IDLE.
//  - Handshake: pixel accepted iff in_valid && in_ready. in_valid low = stall; all counters hold.
//  - FSM: IDLE -> COLLECT on first accepted pixel. COLLECT -> DONE on accepting pixel N-1.
//    DONE lasts exactly 1 cycle, out_valid=1 there, then IDLE.
//  - in_ready = 1 in IDLE and COLLECT, 0 in DONE and while rst.
//  - Raster counters col_cnt, row_cnt: col wraps image_size-1 -> 0 and increments row.
//    Both clear on the last pixel. Accepted pixel p has row=p/image_size, col=p%image_size.
//  - Accept in IDLE, starting a frame: all entries cleared that same cycle. The stale-entry guarantee
//    is that the tail of the last group and unused entries read 0. nnz resets to 0 (write below applies on top).
//  - Accepted pixel != 0: entry[nnz] <= {pixel_in, col_cnt, row_cnt}; nnz <= nnz+1.
//    Zero pixel: no write, nnz unchanged. Order of entries = raster order of non-zeros.
//  - feature_group_num = (nnz+3)>>2, registered; it and nnz both valid and final when out_valid=1.
//  - Hold: lists/counts stay stable from out_valid until the first accept of the next frame.
//  - Latency: out_valid asserts the cycle after the last pixel is accepted.
//  - Widths: coordinates zero-extended/truncated to col_length. nnz max N fits double_word_length.
//    No arithmetic on values.
//  - rst mid-frame: abandons frame, returns to reset state next cycle, no out_valid.
// STRUCTURE
//  - Shared package: MAX_ENTRIES = image_size*image_size, GROUP_SIZE = 4, FSM state encoding.
//  - Shared package: entry-slice index helpers, used identically by PE side.
//  - One sub-module: raster_coord_counter (col/row counters with wrap, last-pixel flag, stall).
//  - Entry storage: generate loop of N registers with per-entry write-enable (index == nnz) and global clear.
// TESTING
//  1. All-zero frame, 784 pixels -> out_valid once at cycle 785; nnz=0, groups=0; all lists 0.
//  2. Single -7 at row 3 col 5 -> nnz=1, groups=1, entry0 = {-7 (8'hF9), col 5, row 3}; entries 1..3 = 0.
//  3. Dense frame of all 1s -> nnz=784, groups=196; entry k col=k%28, row=k/28.
//     Entry 783 = (col 27, row 27).
//  4. Random in_valid gaps, 6 non-zeros -> identical lists to gap-free run; nnz=6, groups=2; no early out_valid.
//  5. Frame A (10 nnz), then frame B (2 nnz) back-to-back -> B entries 2..9 read 0; in_ready=0 in DONE cycle only.
//  6. rst asserted after pixel 400 -> next cycle all outputs 0, IDLE. Fresh frame encodes correctly.
//     No out_valid for the aborted frame.

Source files
------------

// File: rtl/sparse_feature_encoder_pkg.sv
// Shared definitions for the sparse feature encoder and the PE side that
// consumes its flat entry lists.
package sparse_feature_encoder_pkg;

  localparam int COL_LENGTH         = 8;
  localparam int WORD_LENGTH        = 8;
  localparam int DOUBLE_WORD_LENGTH = 16;
  localparam int IMAGE_SIZE         = 28;
  localparam int MAX_ENTRIES        = IMAGE_SIZE * IMAGE_SIZE;
  localparam int GROUP_SIZE         = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } enc_state_e;

  // Most significant bit of entry k in a flat list of w-bit fields.
  function automatic int entry_msb(input int k, input int w);
    return (k + 1) * w - 1;
  endfunction

  // Least significant bit of entry k in a flat list of w-bit fields.
  function automatic int entry_lsb(input int k, input int w);
    return k * w;
  endfunction

  // Number of GROUP_SIZE-entry groups needed to cover nnz entries (ceiling).
  function automatic logic [DOUBLE_WORD_LENGTH-1:0] group_count(
      input logic [DOUBLE_WORD_LENGTH-1:0] nnz);
    return (nnz + DOUBLE_WORD_LENGTH'(GROUP_SIZE - 1)) >> $clog2(GROUP_SIZE);
  endfunction

endpackage

// File: rtl/sparse_feature_encoder_raster_coord_counter.sv
// Raster-order column/row counters for one image. Advances only on accepted
// pixels, wraps the column at the image edge, and flags the last pixel.
module raster_coord_counter
  import sparse_feature_encoder_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  advance_i,
  output logic [COL_LENGTH-1:0] col_o,
  output logic [COL_LENGTH-1:0] row_o,
  output logic                  last_o
);

  localparam logic [COL_LENGTH-1:0] LAST_COORD = COL_LENGTH'(IMAGE_SIZE - 1);

  logic [COL_LENGTH-1:0] col_q, col_d;
  logic [COL_LENGTH-1:0] row_q, row_d;

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign last_o = (col_q == LAST_COORD) && (row_q == LAST_COORD);

  // Next coordinate: hold on stall, clear after the last pixel, else step.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (advance_i) begin
      if (last_o) begin
        col_d = {COL_LENGTH{1'b0}};
        row_d = {COL_LENGTH{1'b0}};
      end else if (col_q == LAST_COORD) begin
        col_d = {COL_LENGTH{1'b0}};
        row_d = row_q + COL_LENGTH'(1);
      end else begin
        col_d = col_q + COL_LENGTH'(1);
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  // Coordinate registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q <= {COL_LENGTH{1'b0}};
      row_q <= {COL_LENGTH{1'b0}};
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/sparse_feature_encoder.sv
// Dense-to-sparse encoder: collects the non-zero pixels of one raster-order
// image into flat (value, col, row) lists and reports entry/group counts.
module sparse_feature_encoder
  import sparse_feature_encoder_pkg::*;
(
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                in_valid_i,
  input  logic [WORD_LENGTH-1:0]              pixel_in_i,
  output logic                                in_ready_o,
  output logic                                out_valid_o,
  output logic [DOUBLE_WORD_LENGTH-1:0]       feature_valid_num_o,
  output logic [DOUBLE_WORD_LENGTH-1:0]       feature_group_num_o,
  output logic [MAX_ENTRIES*WORD_LENGTH-1:0]  feature_value_o,
  output logic [MAX_ENTRIES*COL_LENGTH-1:0]   feature_cols_o,
  output logic [MAX_ENTRIES*COL_LENGTH-1:0]   feature_rows_o
);

  enc_state_e                    state_q, state_d;
  logic [DOUBLE_WORD_LENGTH-1:0] nnz_q, nnz_d;
  logic [DOUBLE_WORD_LENGTH-1:0] group_q, group_d;

  logic                          accept_s;
  logic                          frame_start_s;
  logic                          write_en_s;
  logic [DOUBLE_WORD_LENGTH-1:0] wr_idx_s;
  logic [COL_LENGTH-1:0]         col_s;
  logic [COL_LENGTH-1:0]         row_s;
  logic                          last_s;

  assign in_ready_o    = (state_q != ST_DONE) && !rst_i;
  assign out_valid_o   = (state_q == ST_DONE) && !rst_i;
  assign accept_s      = in_valid_i && in_ready_o;
  assign frame_start_s = accept_s && (state_q == ST_IDLE);
  assign write_en_s    = accept_s && (pixel_in_i != {WORD_LENGTH{1'b0}});
  // A new frame restarts the list at entry 0 regardless of the stale count.
  assign wr_idx_s      = frame_start_s ? {DOUBLE_WORD_LENGTH{1'b0}} : nnz_q;

  assign feature_valid_num_o = nnz_q;
  assign feature_group_num_o = group_q;

  raster_coord_counter u_coord (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .advance_i (accept_s),
    .col_o     (col_s),
    .row_o     (row_s),
    .last_o    (last_s)
  );

  // Frame sequencing: IDLE -> COLLECT on first pixel, DONE for one cycle after the last.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = last_s ? ST_DONE : ST_COLLECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (accept_s && last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Non-zero count and derived group count for the entry being written.
  always_comb begin
    nnz_d = nnz_q;
    if (accept_s) begin
      nnz_d = wr_idx_s + DOUBLE_WORD_LENGTH'(write_en_s);
    end else begin
      nnz_d = nnz_q;
    end
    group_d = group_count(nnz_d);
  end

  // State and count registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      nnz_q   <= {DOUBLE_WORD_LENGTH{1'b0}};
      group_q <= {DOUBLE_WORD_LENGTH{1'b0}};
    end else begin
      state_q <= state_d;
      nnz_q   <= nnz_d;
      group_q <= group_d;
    end
  end

  for (genvar k = 0; k < MAX_ENTRIES; k++) begin : g_entry
    localparam int V_MSB = entry_msb(k, WORD_LENGTH);
    localparam int C_MSB = entry_msb(k, COL_LENGTH);

    logic [WORD_LENGTH-1:0] value_q;
    logic [COL_LENGTH-1:0]  col_q;
    logic [COL_LENGTH-1:0]  row_q;
    logic                   hit_s;

    assign hit_s = write_en_s && (wr_idx_s == DOUBLE_WORD_LENGTH'(k));

    // Entry register: write at the current index wins over the frame-start clear.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        value_q <= {WORD_LENGTH{1'b0}};
        col_q   <= {COL_LENGTH{1'b0}};
        row_q   <= {COL_LENGTH{1'b0}};
      end else if (hit_s) begin
        value_q <= pixel_in_i;
        col_q   <= col_s;
        row_q   <= row_s;
      end else if (frame_start_s) begin
        value_q <= {WORD_LENGTH{1'b0}};
        col_q   <= {COL_LENGTH{1'b0}};
        row_q   <= {COL_LENGTH{1'b0}};
      end
    end

    assign feature_value_o[V_MSB -: WORD_LENGTH] = value_q;
    assign feature_cols_o[C_MSB -: COL_LENGTH]   = col_q;
    assign feature_rows_o[C_MSB -: COL_LENGTH]   = row_q;
  end

endmodule
